riscv_data_responder: RTL and testbench

//  Responder end of the RiscVCore data port: answers load/store requests from the core with

---
 rtl/riscv_data_responder.sv | 159 +++++++++++++++
 tb/tb_riscv_data_responder.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_data_responder.sv
// Data-port responder: zero-wait RAM, timer/compare irq source and console TX FIFO.
// Loads answer combinationally; stores and all register updates commit on the clock edge.
module riscv_data_responder #(
    parameter int unsigned RAM_WORDS  = 1024,
    parameter logic [31:0] IO_BASE    = 32'h8000_0000,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] data_address,
    input  logic [1:0]  data_width,
    input  logic [31:0] data_out,
    input  logic        data_read,
    input  logic        data_write,
    output logic [31:0] data_in,
    output logic        irq,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        bus_error
);
    localparam int AW = $clog2(RAM_WORDS);
    localparam int FW = $clog2(FIFO_DEPTH);

    logic [31:0]   ram [RAM_WORDS];
    logic [7:0]    fifo [FIFO_DEPTH];
    logic [31:0]   timer;
    logic [31:0]   timecmp;
    logic [FW-1:0] wr_ptr;
    logic [FW-1:0] rd_ptr;
    logic [FW:0]   count;
    logic          overflow;

    logic          req;
    logic          ram_hit;
    logic          io_hit;
    logic          misaligned;
    logic          io_width_bad;
    logic          err;
    logic          wr_ok;
    logic [1:0]    sel;
    logic [AW-1:0] word_idx;
    logic [4:0]    shamt;
    logic [3:0]    lane_en;
    logic [31:0]   lane_data;
    logic [31:0]   status;
    logic          ram_we;
    logic          timer_we;
    logic          timecmp_we;
    logic          console_push;
    logic          status_we;
    logic          fifo_full;
    logic          fifo_empty;
    logic          pop;
    logic          push_ok;

    assign req      = data_read | data_write;
    assign ram_hit  = data_address[31:AW+2] == '0;
    assign io_hit   = data_address[31:4] == IO_BASE[31:4];
    assign sel      = data_address[3:2];
    assign word_idx = data_address[AW+1:2];
    assign shamt    = {data_address[1:0], 3'b000};

    assign misaligned = (data_width == 2'd1 && data_address[0])
                     || (data_width == 2'd2 && |data_address[1:0]);
    // Only the console port tolerates byte/half accesses in the IO window.
    assign io_width_bad = io_hit && sel != 2'd2 && data_width != 2'd2;

    assign err = req && ((data_read && data_write) || data_width == 2'd3
                 || misaligned || !(ram_hit || io_hit) || io_width_bad);

    assign wr_ok        = data_write && !err && !reset;
    assign ram_we       = wr_ok && ram_hit;
    assign timer_we     = wr_ok && io_hit && sel == 2'd0;
    assign timecmp_we   = wr_ok && io_hit && sel == 2'd1;
    assign console_push = wr_ok && io_hit && sel == 2'd2;
    assign status_we    = wr_ok && io_hit && sel == 2'd3;

    assign fifo_empty = count == '0;
    assign fifo_full  = count == (FW+1)'(FIFO_DEPTH);
    assign tx_valid   = !fifo_empty;
    assign tx_data    = fifo[rd_ptr];
    assign pop        = tx_valid && tx_ready;
    assign push_ok    = console_push && (!fifo_full || pop);

    assign status = {27'd0, overflow, irq, bus_error, fifo_empty, fifo_full};

    always_comb begin
        lane_en = 4'b1111;
        case (data_width)
            2'd0:    lane_en = 4'b0001 << data_address[1:0];
            2'd1:    lane_en = 4'b0011 << data_address[1:0];
            default: lane_en = 4'b1111;
        endcase
    end

    assign lane_data = data_out << shamt;

    always_comb begin
        data_in = '0;
        if (data_read && !err) begin
            if (ram_hit) begin
                data_in = ram[word_idx] >> shamt;
            end else begin
                case (sel)
                    2'd0:    data_in = timer;
                    2'd1:    data_in = timecmp;
                    default: data_in = status;
                endcase
            end
        end
    end

    always_ff @(posedge clock) begin
        if (ram_we) begin
            for (int i = 0; i < 4; i++) begin
                if (lane_en[i]) ram[word_idx][8*i +: 8] <= lane_data[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (push_ok) fifo[wr_ptr] <= data_out[7:0];
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            timer     <= '0;
            timecmp   <= '1;
            irq       <= 1'b0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            bus_error <= 1'b0;
        end else begin
            timer <= timer_we ? data_out : timer + 32'd1;

            // A TIMECMP write overrides a match seen in the same cycle.
            if (timecmp_we) begin
                timecmp <= data_out;
                irq     <= 1'b0;
            end else if (timer == timecmp) begin
                irq <= 1'b1;
            end

            if (pop) rd_ptr <= rd_ptr + FW'(1);
            if (push_ok) wr_ptr <= wr_ptr + FW'(1);
            if (push_ok && !pop) count <= count + (FW+1)'(1);
            else if (pop && !push_ok) count <= count - (FW+1)'(1);

            if (console_push && !push_ok) overflow <= 1'b1;
            else if (status_we && data_out[4]) overflow <= 1'b0;

            if (err) bus_error <= 1'b1;
            else if (status_we && data_out[2]) bus_error <= 1'b0;
        end
    end
endmodule

// File: tb/tb_riscv_data_responder.sv
// Bench for riscv_data_responder: table vectors, hand-written corner sequences
// and random traffic against a byte-array / queue reference model.
module tb_riscv_data_responder;
    localparam logic [31:0] IO  = 32'h8000_0000;
    localparam logic [31:0] TMR = IO;
    localparam logic [31:0] CMP = IO + 32'd4;
    localparam logic [31:0] CON = IO + 32'd8;
    localparam logic [31:0] STS = IO + 32'd12;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] data_address;
    logic [1:0]  data_width;
    logic [31:0] data_out;
    logic        data_read;
    logic        data_write;
    logic [31:0] data_in;
    logic        irq;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        bus_error;

    always #5 clock = ~clock;

    riscv_data_responder dut (
        .clock(clock), .reset(reset), .data_address(data_address),
        .data_width(data_width), .data_out(data_out), .data_read(data_read),
        .data_write(data_write), .data_in(data_in), .irq(irq),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .bus_error(bus_error)
    );

    int checks = 0;
    int errors = 0;

    logic [7:0]  m_ram [4096];
    logic [31:0] m_timer;
    logic [31:0] m_timecmp;
    logic        m_irq;
    logic        m_err;
    logic        m_ovf;
    logic [7:0]  m_q [$];

    typedef struct {
        logic [31:0] din;
        logic        irq;
        logic        err;
        logic        tv;
        logic [7:0]  td;
    } obs_t;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [1:0]  w;
        logic [31:0] a;
        logic [31:0] d;
        logic [31:0] din;
        logic        err;
    } vec_t;

    vec_t vt [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] m_status();
        return {27'd0, m_ovf, m_irq, m_err, m_q.size() == 0, m_q.size() == 8};
    endfunction

    function automatic void model_reset();
        m_timer   = 32'd0;
        m_timecmp = 32'hFFFF_FFFF;
        m_irq     = 1'b0;
        m_err     = 1'b0;
        m_ovf     = 1'b0;
        m_q.delete();
    endfunction

    task automatic model_step(input logic rd, input logic wr, input logic [1:0] w,
                              input logic [31:0] a, input logic [31:0] d,
                              input logic rdy, output logic [31:0] din);
        logic        in_ram, in_io, mis, bad, full0, pop, nxt_irq;
        logic [31:0] base, word, nxt_timer;
        int          sel, n;
        in_ram = a < 32'd4096;
        in_io  = a >= IO && a < IO + 32'd16;
        mis    = (w == 2'd1 && a % 2 != 0) || (w == 2'd2 && a % 4 != 0);
        sel    = int'((a - IO) / 4);
        bad    = (rd || wr) && ((rd && wr) || w == 2'd3 || mis
                 || !(in_ram || in_io) || (in_io && sel != 2 && w != 2'd2));
        din = 32'd0;
        if (rd && !bad) begin
            if (in_ram) begin
                base = a - a % 4;
                word = {m_ram[base+3], m_ram[base+2], m_ram[base+1], m_ram[base]};
                din  = word >> (8 * (a % 4));
            end else if (sel == 0) din = m_timer;
            else if (sel == 1) din = m_timecmp;
            else din = m_status();
        end
        full0     = m_q.size() == 8;
        pop       = rdy && m_q.size() > 0;
        nxt_timer = m_timer + 32'd1;
        nxt_irq   = m_irq || (m_timer == m_timecmp);
        if (pop) void'(m_q.pop_front());
        if (bad) m_err = 1'b1;
        if (wr && !bad) begin
            if (in_ram) begin
                n = (w == 2'd0) ? 1 : (w == 2'd1) ? 2 : 4;
                for (int k = 0; k < n; k++) m_ram[a+k] = d[8*k +: 8];
            end else if (sel == 0) begin
                nxt_timer = d;
            end else if (sel == 1) begin
                m_timecmp = d;
                nxt_irq   = 1'b0;
            end else if (sel == 2) begin
                if (!full0 || pop) m_q.push_back(d[7:0]);
                else m_ovf = 1'b1;
            end else begin
                if (d[2]) m_err = 1'b0;
                if (d[4]) m_ovf = 1'b0;
            end
        end
        m_timer = nxt_timer;
        m_irq   = nxt_irq;
    endtask

    task automatic cyc(input logic rd, input logic wr, input logic [1:0] w,
                       input logic [31:0] a, input logic [31:0] d,
                       input logic rdy, output obs_t o);
        logic [31:0] din;
        data_read    = rd;
        data_write   = wr;
        data_width   = w;
        data_address = a;
        data_out     = d;
        tx_ready     = rdy;
        @(negedge clock);
        o.din = data_in;
        o.irq = irq;
        o.err = bus_error;
        o.tv  = tx_valid;
        o.td  = tx_data;
        chk("irq", irq, m_irq);
        chk("bus_error", bus_error, m_err);
        chk("tx_valid", tx_valid, m_q.size() != 0);
        if (m_q.size() != 0) chk("tx_data", tx_data, m_q[0]);
        model_step(rd, wr, w, a, d, rdy, din);
        chk("data_in", data_in, din);
        @(posedge clock);
        #1;
        data_read  = 1'b0;
        data_write = 1'b0;
    endtask

    task automatic do_reset(input logic wr, input logic [31:0] a, input logic [31:0] d);
        reset        = 1'b1;
        data_read    = 1'b0;
        data_write   = wr;
        data_width   = 2'd2;
        data_address = a;
        data_out     = d;
        tx_ready     = 1'b0;
        @(posedge clock);
        #1;
        reset      = 1'b0;
        data_write = 1'b0;
        model_reset();
    endtask

    function automatic void add(logic rd, logic wr, logic [1:0] w, logic [31:0] a,
                                logic [31:0] d, logic [31:0] din, logic err);
        vec_t v;
        v.rd = rd; v.wr = wr; v.w = w; v.a = a; v.d = d; v.din = din; v.err = err;
        vt.push_back(v);
    endfunction

    initial begin
        obs_t        o;
        logic [31:0] a, d;
        logic [1:0]  w;
        logic        rd, wr;
        int          r;

        do_reset(1'b0, 32'd0, 32'd0);
        cyc(1, 0, 2, TMR, 0, 0, o);
        chk("reset timer", o.din, 32'd0);
        cyc(1, 0, 2, STS, 0, 0, o);
        chk("reset status", o.din, 32'h2);
        chk("reset irq", o.irq, 1'b0);
        cyc(1, 0, 2, CMP, 0, 0, o);
        chk("reset timecmp", o.din, 32'hFFFF_FFFF);

        for (int i = 0; i < 16; i++) cyc(0, 1, 2, 32'(i * 4), $urandom, 0, o);

        add(0, 1, 2, 32'h10, 32'h1122_3344, 32'h0, 0);
        add(1, 0, 0, 32'h11, 32'h0, 32'h0011_2233, 0);
        add(1, 0, 1, 32'h12, 32'h0, 32'h0000_1122, 0);
        add(0, 1, 0, 32'h13, 32'h1234_56AB, 32'h0, 0);
        add(1, 0, 2, 32'h10, 32'h0, 32'hAB22_3344, 0);
        add(1, 0, 1, 32'h11, 32'h0, 32'h0, 0);
        add(1, 0, 2, 32'h10, 32'h0, 32'hAB22_3344, 1);
        add(0, 1, 2, STS, 32'h4, 32'h0, 1);
        add(1, 0, 2, STS, 32'h0, 32'h2, 0);
        add(1, 0, 1, CMP, 32'h0, 32'h0, 0);
        add(1, 0, 2, STS, 32'h0, 32'h6, 1);
        add(1, 1, 2, 32'h10, 32'h0, 32'h0, 1);
        add(1, 0, 3, 32'h10, 32'h0, 32'h0, 1);
        add(1, 0, 2, 32'h1000, 32'h0, 32'h0, 1);
        add(0, 1, 2, 32'h1000, 32'h5555_5555, 32'h0, 1);
        add(1, 0, 2, 32'h10, 32'h0, 32'hAB22_3344, 1);
        add(0, 1, 2, STS, 32'h14, 32'h0, 1);
        add(1, 0, 2, STS, 32'h0, 32'h2, 0);
        for (int i = 0; i < vt.size(); i++) begin
            cyc(vt[i].rd, vt[i].wr, vt[i].w, vt[i].a, vt[i].d, 0, o);
            chk($sformatf("vec%0d data_in", i), o.din, vt[i].din);
            chk($sformatf("vec%0d bus_error", i), o.err, vt[i].err);
        end

        // irq timing: cycle k after reset shows timer == k
        do_reset(1'b0, 32'd0, 32'd0);
        cyc(0, 1, 2, CMP, 32'd20, 0, o);
        for (int k = 1; k <= 25; k++) begin
            cyc(0, 0, 2, 0, 0, 0, o);
            chk($sformatf("irq cycle %0d", k), o.irq, k >= 21);
        end
        cyc(0, 1, 2, CMP, 32'd100, 0, o);
        chk("irq held", o.irq, 1'b1);
        cyc(0, 0, 2, 0, 0, 0, o);
        chk("irq cleared", o.irq, 1'b0);
        cyc(1, 0, 2, TMR, 0, 0, o);
        chk("timer count", o.din, 32'd28);

        cyc(0, 1, 2, TMR, 32'hFFFF_FFF0, 0, o);
        cyc(0, 1, 2, CMP, 32'd50, 0, o);
        cyc(0, 1, 2, TMR, 32'hFFFF_FFFE, 0, o);
        cyc(1, 0, 2, TMR, 0, 0, o);
        chk("timer load", o.din, 32'hFFFF_FFFE);
        cyc(1, 0, 2, TMR, 0, 0, o);
        chk("timer max", o.din, 32'hFFFF_FFFF);
        cyc(1, 0, 2, TMR, 0, 0, o);
        chk("timer wrap", o.din, 32'h0);
        for (int k = 0; k < 3; k++) begin
            cyc(0, 0, 2, 0, 0, 0, o);
            chk("no spurious irq", o.irq, 1'b0);
        end

        // console FIFO overflow, drain order, full push+pop
        do_reset(1'b0, 32'd0, 32'd0);
        for (int i = 0; i < 9; i++) cyc(0, 1, 0, CON, 32'(8'h41 + i), 0, o);
        cyc(1, 0, 2, STS, 0, 0, o);
        chk("fifo overflow status", o.din, 32'h11);
        for (int i = 0; i < 8; i++) begin
            cyc(0, 0, 2, 0, 0, 1, o);
            chk("drain valid", o.tv, 1'b1);
            chk($sformatf("drain byte %0d", i), o.td, 8'(8'h41 + i));
        end
        cyc(0, 0, 2, 0, 0, 1, o);
        chk("drained empty", o.tv, 1'b0);
        cyc(0, 1, 2, STS, 32'h10, 0, o);
        for (int i = 0; i < 8; i++) cyc(0, 1, 0, CON, 32'(8'h61 + i), 0, o);
        cyc(0, 1, 0, CON, 32'h5A, 1, o);
        chk("push+pop head", o.td, 8'h61);
        cyc(1, 0, 2, STS, 0, 0, o);
        chk("still full", o.din, 32'h1);
        for (int i = 0; i < 8; i++) begin
            cyc(0, 0, 2, 0, 0, 1, o);
            chk($sformatf("pp byte %0d", i), o.td, (i < 7) ? 8'(8'h62 + i) : 8'h5A);
        end

        cyc(0, 1, 2, 32'h20, 32'h600D_F00D, 0, o);
        cyc(0, 1, 0, CON, 32'h51, 0, o);
        do_reset(1'b1, 32'h20, 32'hDEAD_BEEF);
        cyc(1, 0, 2, 32'h20, 0, 0, o);
        chk("reset empties fifo", o.tv, 1'b0);
        chk("reset drops store", o.din, 32'h600D_F00D);

        for (int n = 0; n < 3000; n++) begin
            r = int'($urandom_range(0, 9));
            if (r < 5) a = 32'($urandom_range(0, 63));
            else if (r < 8) a = IO + 32'($urandom_range(0, 15));
            else begin
                case ($urandom_range(0, 4))
                    0: a = 32'h0000_1000;
                    1: a = 32'h0000_FFFC;
                    2: a = IO + 32'd16;
                    3: a = 32'h7FFF_FFFC;
                    default: a = 32'hFFFF_FFFF;
                endcase
            end
            r  = int'($urandom_range(0, 9));
            w  = (r < 9) ? 2'(r % 3) : 2'd3;
            r  = int'($urandom_range(0, 9));
            rd = r < 5 || r == 9;
            wr = (r >= 5 && r < 9) || (r == 9 && $urandom_range(0, 1) == 1);
            d  = $urandom;
            cyc(rd, wr, w, a, d, 1'($urandom_range(0, 1)), o);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
